// File: rtl/poci_shift_out_if.sv
// Byte-stream bundle between the PICO receiver side and the POCI transmitter.
// The master modport is the controller/PICO side; the slave modport is the transmitter.
interface poci_shift_out_if #(
  parameter int unsigned CNT_W = 8
);
  logic             msg_flag;
  logic [7:0]       mux_control_signal;
  logic [7:0]       reg_rdata;
  logic             serial_out;
  logic             serial_oe;
  logic [CNT_W-1:0] byte_cnt;
  logic             sync_err;

  modport master (
    output msg_flag, mux_control_signal, reg_rdata,
    input  serial_out, serial_oe, byte_cnt, sync_err
  );

  modport slave (
    input  msg_flag, mux_control_signal, reg_rdata,
    output serial_out, serial_oe, byte_cnt, sync_err
  );
endinterface

// File: rtl/poci_shift_out.sv
// POCI transmitter: loads a header or register byte at every byte boundary, shifts it MSB-first.
// Define POCI_STATUS_EN to carry the sticky sync_err in bit 0 of the header byte.
module poci_shift_out #(
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter logic [7:0]  HEADER     = 8'hA4,
  parameter int unsigned CNT_W      = 8
) (
  input logic             sclk,
  input logic             rstn,
  poci_shift_out_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             sync_err_q, sync_err_d;
  logic [7:0]       header;

`ifdef POCI_STATUS_EN
  assign header = {HEADER[7:1], sync_err_q};
`else
  logic unused_header;
  assign unused_header = ^HEADER;
  assign header        = 8'h00;
`endif

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sync_err_d = sync_err_q;
    if (bus.msg_flag) begin
      // A boundary anywhere but after the LSB is flagged, but we still realign to it.
      if ((state_q != StIdle) && (bit_cnt_q != 3'd7)) begin
        sync_err_d = 1'b1;
      end
      bit_cnt_d = 3'd0;
      if (bus.mux_control_signal == 8'h00) begin
        shreg_d    = header;
        state_d    = StHdr;
        byte_cnt_d = CNT_W'(1);
      end else begin
        shreg_d    = bus.reg_rdata;
        state_d    = StData;
        byte_cnt_d = (byte_cnt_q == CntMax) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
      end
    end else begin
      unique case (state_q)
        StHdr, StData: begin
          if (bit_cnt_q == 3'd7) begin
            // Missing boundary after the LSB: stop driving the pad.
            sync_err_d = 1'b1;
            state_d    = StIdle;
          end else begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.serial_out = (state_q == StIdle) ? IDLE_LEVEL : shreg_q[7];
  assign bus.serial_oe  = (state_q != StIdle);
  assign bus.byte_cnt   = byte_cnt_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_poci_shift_out.sv
// Self-checking bench for poci_shift_out: byte-level reference model of the PICO/POCI exchange.
module tb_poci_shift_out;
  localparam logic        IdleLevel = 1'b0;
  localparam logic [7:0]  Header    = 8'hA4;
  localparam int unsigned CntW      = 8;

  logic clk_free = 1'b0;
  logic clk_en   = 1'b1;
  logic sclk;
  logic rstn;

  always #5 clk_free = ~clk_free;
  assign sclk = clk_free & clk_en;

  poci_shift_out_if #(.CNT_W(CntW)) bus ();

  logic [7:0] regs [256];
  assign bus.reg_rdata = regs[bus.mux_control_signal];

  poci_shift_out #(
    .IDLE_LEVEL (IdleLevel),
    .HEADER     (Header),
    .CNT_W      (CntW)
  ) dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cnt_m    = 0;
  logic err_m  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hdr_exp(input logic err);
`ifdef POCI_STATUS_EN
    return {Header[7:1], err};
`else
    return 8'h00 & {8{err}};
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] ptr);
    return (ptr == 8'h00) ? hdr_exp(err_m) : regs[ptr];
  endfunction

  function automatic void model_load(input logic [7:0] ptr);
    if (ptr == 8'h00) cnt_m = 1;
    else if (cnt_m < 255) cnt_m = cnt_m + 1;
  endfunction

  // Drive one sclk period; sample serial_out on the falling edge.
  task automatic tick(input logic flag, input logic [7:0] ptr, output logic b);
    bus.msg_flag           = flag;
    bus.mux_control_signal = ptr;
    @(posedge clk_free);
    @(negedge clk_free);
    b = bus.serial_out;
  endtask

  task automatic shift_bits(input logic [7:0] ptr, input int nbits, output logic [7:0] got);
    logic b;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      tick(i == 0, ptr, b);
      got = {got[6:0], b};
    end
  endtask

  task automatic xfer_byte(input logic [7:0] ptr, input string tag);
    logic [7:0] exp;
    logic [7:0] got;
    exp = exp_byte(ptr);
    model_load(ptr);
    shift_bits(ptr, 8, got);
    check_eq({tag, "_data"}, 32'(got), 32'(exp));
    check_eq({tag, "_cnt"}, 32'(bus.byte_cnt), 32'(cnt_m));
    check_eq({tag, "_oe"}, 32'(bus.serial_oe), 32'd1);
    check_eq({tag, "_err"}, 32'(bus.sync_err), 32'(err_m));
  endtask

  // Transaction end: PICO's stop reset forces msg_flag=1, pointer=0 while sclk is stopped.
  task automatic sclk_gap();
    bus.msg_flag           = 1'b1;
    bus.mux_control_signal = 8'h00;
    clk_en                 = 1'b0;
    repeat (4) @(negedge clk_free);
    clk_en = 1'b1;
  endtask

  task automatic run_txn(input logic [7:0] addr, input int n, input logic wr,
                         input logic [7:0] wval, input logic rnd, input string tag);
    logic [7:0] ptr;
    xfer_byte(8'h00, {tag, "_hdr"});
    ptr = addr;
    for (int k = 0; k < n; k++) begin
      xfer_byte(ptr, tag);
      if (wr && ptr != 8'h00) regs[ptr] = rnd ? 8'($urandom) : wval;
      ptr = ptr + 8'd1;
    end
    sclk_gap();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       b;
    logic [7:0] got;
    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    rstn                   = 1'b0;
    bus.msg_flag           = 1'b1;
    bus.mux_control_signal = 8'h00;
    tick(1'b1, 8'h00, b);
    tick(1'b1, 8'h00, b);
    check_eq("rst_out", 32'(b), 32'(IdleLevel));
    check_eq("rst_oe", 32'(bus.serial_oe), 32'd0);
    check_eq("rst_cnt", 32'(bus.byte_cnt), 32'd0);
    check_eq("rst_err", 32'(bus.sync_err), 32'd0);
    rstn = 1'b1;

    // Read burst and read-before-write.
    regs[5] = 8'h3C;
    regs[6] = 8'h81;
    run_txn(8'h05, 2, 1'b0, 8'h00, 1'b0, "burst");
    run_txn(8'h05, 1, 1'b1, 8'hFF, 1'b0, "rbw_wr");
    run_txn(8'h05, 1, 1'b0, 8'h00, 1'b0, "rbw_rd");

    // Pointer wrap: FE, FF, header, 01.
    run_txn(8'hFE, 4, 1'b0, 8'h00, 1'b0, "wrap");

    for (int t = 0; t < 12; t++) begin
      run_txn(8'($urandom_range(1, 255)), $urandom_range(1, 5), 1'($urandom_range(0, 1)),
              8'h00, 1'b1, "rnd");
    end

    // Misalignment: early boundary at bit 3, then missing boundary after bit 7.
    xfer_byte(8'h00, "mis_hdr");
    model_load(8'h20);
    shift_bits(8'h20, 4, got);
    check_eq("mis_part", 32'(got[3:0]), 32'(regs[8'h20][7:4]));
    err_m = 1'b1;
    xfer_byte(8'h21, "mis_realign");
    tick(1'b0, 8'h22, b);
    check_eq("drop_out", 32'(b), 32'(IdleLevel));
    check_eq("drop_oe", 32'(bus.serial_oe), 32'd0);
    check_eq("drop_err", 32'(bus.sync_err), 32'd1);
    xfer_byte(8'h00, "err_hdr");
    sclk_gap();
    run_txn(8'h40, 2, 1'b0, 8'h00, 1'b0, "after_err");

    // Reset for one edge mid-byte.
    shift_bits(8'h30, 3, got);
    rstn = 1'b0;
    tick(1'b0, 8'h30, b);
    rstn = 1'b1;
    check_eq("midrst_out", 32'(b), 32'(IdleLevel));
    check_eq("midrst_oe", 32'(bus.serial_oe), 32'd0);
    check_eq("midrst_cnt", 32'(bus.byte_cnt), 32'd0);
    check_eq("midrst_err", 32'(bus.sync_err), 32'd0);
    err_m = 1'b0;
    cnt_m = 0;
    sclk_gap();
    run_txn(8'h07, 2, 1'b0, 8'h00, 1'b0, "post_rst");

    // byte_cnt saturation, then wrap to a header restarting the count.
    run_txn(8'h01, 256, 1'b0, 8'h00, 1'b0, "sat");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
